// File: rtl/flash_qspi_reader.sv
// Quad-I/O (EBh) line fetch engine for an external SPI flash; fsclk = HCLK/2, SPI mode 0.
// Latency: first rd_valid 2*(16+DUMMY_CYCLES+8) HCLK after accept, then one word every 16 HCLK.
// Backpressure: req_ready only in IDLE (no queuing); rd_valid has no backpressure, consumer must take it.
// Ports: HCLK/HRESETn clock and async active-low reset; req_valid/req_ready/req_addr line request;
//   rd_data/rd_valid/rd_last returned words (little-endian); busy transaction in flight;
//   fsclk/fcen/fdo/fdoe/fdi flash pad interface (SIO[3:0] shared output enable).
module flash_qspi_reader #(
  parameter int unsigned LINE_WORDS   = 4,
  parameter int unsigned DUMMY_CYCLES = 4,
  parameter int unsigned CSH_CYCLES   = 2,
  parameter logic [7:0]  MODE_BYTE    = 8'hFF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        busy,
  output logic        fsclk,
  output logic        fcen,
  output logic [3:0]  fdo,
  output logic        fdoe,
  input  logic [3:0]  fdi
);

  localparam logic [7:0]  OPCODE  = 8'hEB;
  localparam int unsigned CNT_MAX = (DUMMY_CYCLES > 8) ? DUMMY_CYCLES : 8;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam int unsigned WW      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned HW      = (CSH_CYCLES > 1) ? $clog2(CSH_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_DESEL
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [WW-1:0] word_cnt;
  logic [HW-1:0] csh_cnt;
  logic [23:0]   addr_q;
  logic [27:0]   rx_sh;
  logic [31:0]   rx_word;
  logic [7:0]    opc_sh;
  logic [23:0]   addr_sh;
  logic [3:0]    fdo_nxt;
  logic          fdoe_nxt;
  logic          phase_end, word_end, line_end;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  // First nibble received ends up in [31:28]; byte order is reversed below.
  assign rx_word   = {rx_sh, fdi};

  // In the active states fsclk is high for one HCLK, so a cycle with fsclk=1
  // is always the edge that drops SCK: fdo shifts, fdi is sampled, counters step.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    phase_end = 1'b0;
    word_end  = 1'b0;
    line_end  = 1'b0;
    fdo_nxt   = 4'b1100;
    fdoe_nxt  = 1'b0;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = S_CMD;
      S_CMD: begin
        phase_end = (cnt == CW'(7));
        if (fsclk && phase_end) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        phase_end = (cnt == CW'(5));
        if (fsclk && phase_end) state_nxt = S_MODE;
      end
      S_MODE: begin
        phase_end = (cnt == CW'(1));
        if (fsclk && phase_end) state_nxt = S_DUMMY;
      end
      S_DUMMY: begin
        phase_end = (cnt == CW'(DUMMY_CYCLES - 1));
        if (fsclk && phase_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        phase_end = (cnt == CW'(7));
        word_end  = fsclk && phase_end;
        line_end  = word_end && (word_cnt == WW'(LINE_WORDS - 1));
        if (line_end) state_nxt = S_DESEL;
      end
      S_DESEL: if (csh_cnt == HW'(CSH_CYCLES - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (state == S_IDLE)  cnt_nxt = '0;
    else if (fsclk)       cnt_nxt = phase_end ? '0 : cnt + 1'b1;

    // Pad value for the SCK period that starts on this edge.
    opc_sh  = OPCODE << cnt_nxt[2:0];
    addr_sh = addr_q << {cnt_nxt[2:0], 2'b00};
    case (state_nxt)
      S_CMD: begin
        fdo_nxt  = {3'b110, opc_sh[7]};
        fdoe_nxt = 1'b1;
      end
      S_ADDR: begin
        fdo_nxt  = addr_sh[23:20];
        fdoe_nxt = 1'b1;
      end
      S_MODE: begin
        fdo_nxt  = cnt_nxt[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
        fdoe_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt      <= '0;
      word_cnt <= '0;
      csh_cnt  <= '0;
      addr_q   <= '0;
      rx_sh    <= '0;
      fsclk    <= 1'b0;
      fcen     <= 1'b1;
      fdo      <= 4'b1100;
      fdoe     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= word_end;
      rd_last  <= line_end;
      cnt      <= cnt_nxt;
      case (state)
        S_IDLE: begin
          fsclk    <= 1'b0;
          word_cnt <= '0;
          csh_cnt  <= '0;
          if (req_valid) begin
            addr_q <= {req_addr[23:2], 2'b00};
            fcen   <= 1'b0;
            fdo    <= fdo_nxt;
            fdoe   <= fdoe_nxt;
          end
        end
        S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA: begin
          fsclk <= ~fsclk;
          if (fsclk) begin
            fdo  <= fdo_nxt;
            fdoe <= fdoe_nxt;
            if (state == S_DATA) rx_sh <= {rx_sh[23:0], fdi};
          end
          if (word_end) begin
            rd_data  <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
            word_cnt <= line_end ? '0 : word_cnt + 1'b1;
          end
          if (line_end) fcen <= 1'b1;
        end
        S_DESEL: csh_cnt <= csh_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_qspi_reader.sv
// Directed bench for flash_qspi_reader with a behavioural quad-I/O flash model.
// Latency: checks 56 HCLK to first word and 16 HCLK spacing at default parameters.
// Backpressure: exercises request-while-busy rejection and back-to-back requests.
module tb_flash_qspi_reader;

  localparam int DUMMY = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        busy;
  logic        fsclk;
  logic        fcen;
  logic [3:0]  fdo;
  logic        fdoe;
  logic [3:0]  fdi = 4'h0;

  always #5 HCLK = ~HCLK;

  flash_qspi_reader dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy),
    .fsclk(fsclk), .fcen(fcen), .fdo(fdo), .fdoe(fdoe), .fdi(fdi)
  );

  // Flash model: decodes command/address/mode on rising SCK, drives data after falling SCK.
  // Memory content: byte at address a is a[7:0] ^ a[23:16].
  int          m_cnt   = 0;
  int          sck_all = 0;
  int          viol    = 0;
  int          m_j;
  logic [7:0]  m_cmd   = 8'h00;
  logic [23:0] m_addr  = 24'h0;
  logic [7:0]  m_mode  = 8'h00;
  logic [23:0] m_b;
  logic [7:0]  m_v;

  always @(posedge fcen or posedge fsclk or negedge fsclk) begin
    if (fcen) begin
      m_cnt = 0;
    end else if (fsclk) begin
      sck_all++;
      if (m_cnt < 8) begin
        m_cmd = {m_cmd[6:0], fdo[0]};
        if (fdo[3:1] !== 3'b110) viol++;
      end else if (m_cnt < 14) begin
        m_addr = {m_addr[19:0], fdo};
      end else if (m_cnt < 16) begin
        m_mode = {m_mode[3:0], fdo};
      end
      if (fdoe !== ((m_cnt < 16) ? 1'b1 : 1'b0)) viol++;
      m_cnt++;
    end else if (m_cnt >= 16 + DUMMY) begin
      m_j = m_cnt - (16 + DUMMY);
      m_b = m_addr + 24'(m_j / 2);
      m_v = m_b[7:0] ^ m_b[23:16];
      fdi = m_j[0] ? m_v[3:0] : m_v[7:4];
    end
  end

  int          nchk = 0;
  int          nerr = 0;
  int          ncyc = 0;
  int          hi_run = 0;
  int          min_gap = 1000;
  bit          seen_low = 1'b0;
  logic [31:0] wq[$];
  logic        lq[$];
  int          tq[$];
  int          acc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling HCLK edge and record what the DUT shows there.
  task automatic step();
    if (req_valid && req_ready) acc_q.push_back(ncyc + 1);
    @(negedge HCLK);
    ncyc++;
    if (rd_valid) begin
      wq.push_back(rd_data);
      lq.push_back(rd_last);
      tq.push_back(ncyc);
    end
    if (fcen) hi_run++;
    else begin
      if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
      hi_run   = 0;
      seen_low = 1'b1;
    end
  endtask

  task automatic clear_q();
    wq.delete(); lq.delete(); tq.delete(); acc_q.delete();
  endtask

  task automatic wait_accept(input int budget);
    int k = 0;
    int n0 = acc_q.size();
    while (acc_q.size() == n0 && k < budget) begin step(); k++; end
    req_valid = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, input int tail);
    int k = 0;
    while (wq.size() < n && k < budget) begin step(); k++; end
    repeat (tail) step();
  endtask

  logic [31:0] e1[4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
  logic [31:0] e5[4] = '{32'h43424140, 32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C};

  initial begin
    int s0;
    int nlast;
    int k;
    HRESETn   = 1'b0;
    req_valid = 1'b0;
    req_addr  = 24'h0;
    repeat (3) step();
    chk("rst_fcen", fcen, 1);
    chk("rst_fsclk", fsclk, 0);
    chk("rst_fdoe", fdoe, 0);
    chk("rst_fdo", fdo, 4'hC);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);
    HRESETn = 1'b1;
    step();
    chk("rst_req_ready", req_ready, 1);

    // Basic line at 0x000000 plus pin-level checks.
    clear_q();
    s0 = sck_all;
    req_addr = 24'h000000; req_valid = 1'b1;
    wait_accept(20);
    chk("t1_accepted", acc_q.size(), 1);
    chk("t2_fdo_first", fdo, 4'hD);
    chk("t2_fdoe_first", fdoe, 1);
    chk("t2_fcen_low", fcen, 0);
    chk("t1_busy", busy, 1);
    chk("t1_ready_busy", req_ready, 0);
    step();
    chk("t2_fsclk_rise", fsclk, 1);
    wait_words(4, 200, 10);
    chk("t1_nwords", wq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_word%0d", i), wq[i], e1[i]);
      chk($sformatf("t1_last%0d", i), lq[i], (i == 3) ? 1 : 0);
    end
    chk("t1_latency", tq[0] - acc_q[0], 56);
    chk("t1_spacing", tq[3] - tq[0], 48);
    chk("t2_opcode", m_cmd, 8'hEB);
    chk("t2_addr", m_addr, 24'h000000);
    chk("t2_mode", m_mode, 8'hFF);
    chk("t2_sck_count", sck_all - s0, 52);
    chk("t2_pin_viol", viol, 0);
    chk("t1_fcen_end", fcen, 1);
    chk("t1_fsclk_end", fsclk, 0);
    chk("t1_idle", req_ready, 1);

    // Low address bits ignored.
    clear_q();
    req_addr = 24'h000013; req_valid = 1'b1;
    wait_accept(20);
    wait_words(4, 200, 10);
    chk("t3_nwords", wq.size(), 4);
    chk("t3_word0", wq[0], 32'h13121110);
    chk("t3_word3", wq[3], 32'h1F1E1D1C);
    chk("t3_addr", m_addr, 24'h000010);

    clear_q();
    req_addr = 24'h5A0013; req_valid = 1'b1;
    wait_accept(20);
    wait_words(4, 200, 10);
    chk("t3b_word0", wq[0], 32'h49484B4A);
    chk("t3b_addr", m_addr, 24'h5A0010);

    // Back-to-back lines with req_valid held.
    clear_q();
    min_gap = 1000;
    req_addr = 24'h000020; req_valid = 1'b1;
    k = 0;
    while (acc_q.size() < 2 && k < 400) begin
      step(); k++;
      if (acc_q.size() == 1) req_addr = 24'h000030;
    end
    req_valid = 1'b0;
    wait_words(8, 300, 10);
    chk("t4_accepts", acc_q.size(), 2);
    chk("t4_nwords", wq.size(), 8);
    nlast = 0;
    foreach (lq[i]) if (lq[i]) nlast++;
    chk("t4_nlast", nlast, 2);
    chk("t4_last3", lq[3], 1);
    chk("t4_last7", lq[7], 1);
    chk("t4_word0", wq[0], 32'h23222120);
    chk("t4_word4", wq[4], 32'h33323130);
    chk("t4_word7", wq[7], 32'h3F3E3D3C);
    chk("t4_gap_ge_csh", (min_gap >= 2) ? 1 : 0, 1);

    // Reset during the second data word.
    clear_q();
    req_addr = 24'h000040; req_valid = 1'b1;
    wait_accept(20);
    wait_words(1, 100, 6);
    HRESETn = 1'b0;
    #1;
    chk("t5_fcen", fcen, 1);
    chk("t5_fsclk", fsclk, 0);
    chk("t5_fdoe", fdoe, 0);
    chk("t5_busy", busy, 0);
    repeat (3) step();
    HRESETn = 1'b1;
    repeat (30) step();
    chk("t5_no_more_words", wq.size(), 1);
    clear_q();
    req_addr = 24'h000040; req_valid = 1'b1;
    wait_accept(20);
    wait_words(4, 200, 10);
    chk("t5_nwords", wq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_word%0d", i), wq[i], e5[i]);
    chk("t5_latency", tq[0] - acc_q[0], 56);

    // Request pulsed while busy is ignored.
    clear_q();
    req_addr = 24'h000020; req_valid = 1'b1;
    wait_accept(20);
    repeat (5) step();
    req_addr = 24'h000080; req_valid = 1'b1;
    chk("t6_ready_busy", req_ready, 0);
    step();
    req_valid = 1'b0;
    wait_words(4, 200, 100);
    chk("t6_accepts", acc_q.size(), 1);
    chk("t6_nwords", wq.size(), 4);
    chk("t6_word0", wq[0], 32'h23222120);
    chk("t6_word3", wq[3], 32'h2F2E2D2C);
    chk("t6_addr", m_addr, 24'h000020);
    chk("t6_pin_viol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
